muldiv_seq: RTL and testbench

Parametrised iterative multiply/divide sequencer for the multicycle processor datapath. It executes the four extended ALU operations selected by ALUControl codes 3'b100–3'b111: MUL, SMUL, UMUL and DIV. Operations run over a fixed number of cycles, one bit per cycle, so the wide operators no longer sit in the single-cycle ALU path. The main FSM starts it with a one-cycle pulse, holds in its execute state while `busy` is high, and writes back on `done`.

---
 rtl/muldiv_seq.sv | 153 +++++++++++++++
 tb/tb_muldiv_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer: MUL, SMUL, UMUL and unsigned DIV, one bit per cycle.
// Fixed latency of WIDTH+2 cycles from an accepted start to the done pulse.
`timescale 1ns/1ps
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ResultLo,
    output logic [WIDTH-1:0] ResultHi,
    output logic             DivZero
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_SMUL = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b11;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t             state_reg;
    logic [1:0]         op_reg;
    logic               neg_reg;
    logic [WIDTH-1:0]   opa_reg;    // multiplicand, or divisor for DIV
    logic [2*WIDTH-1:0] acc_reg;    // {upper, multiplier} or {remainder, quotient}
    logic [CNT_W-1:0]   cnt_reg;

    logic               accept;
    logic [WIDTH-1:0]   a_mag, b_mag, cap_opa, cap_low;
    logic               cap_neg;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic               div_borrow;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] fix_prod;
    logic [WIDTH-1:0]   fix_lo, fix_hi;
    logic               fix_dz;

    always_comb begin
        accept  = start && ALUControl[2] && (state_reg == IDLE || state_reg == DONE);
        a_mag   = SrcA[WIDTH-1] ? (WIDTH'(0) - SrcA) : SrcA;
        b_mag   = SrcB[WIDTH-1] ? (WIDTH'(0) - SrcB) : SrcB;
        cap_opa = SrcA;
        cap_low = SrcB;
        cap_neg = 1'b0;
        case (ALUControl[1:0])
            OP_SMUL: begin
                cap_opa = a_mag;
                cap_low = b_mag;
                cap_neg = SrcA[WIDTH-1] ^ SrcB[WIDTH-1];
            end
            OP_DIV: begin
                cap_opa = SrcB;
                cap_low = SrcA;
            end
            default: ;
        endcase
    end

    // Shift-add step: the carry out of the upper-half add lands in the MSB after the shift.
    always_comb begin
        mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opa_reg} : '0);
        mul_next = {mul_sum, acc_reg[WIDTH-1:1]};
    end

    // Restoring step; the partial remainder needs one extra bit after the shift.
    always_comb begin
        div_shift  = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
        div_diff   = {1'b0, div_shift} - {2'b00, opa_reg};
        div_borrow = div_diff[WIDTH+1];
        div_next   = {(div_borrow ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                      acc_reg[WIDTH-2:0], ~div_borrow};
    end

    always_comb begin
        fix_prod = neg_reg ? ((2*WIDTH)'(0) - acc_reg) : acc_reg;
        fix_lo   = fix_prod[WIDTH-1:0];
        fix_hi   = fix_prod[2*WIDTH-1:WIDTH];
        fix_dz   = 1'b0;
        case (op_reg)
            OP_MUL: fix_hi = '0;
            OP_DIV: begin
                fix_lo = acc_reg[WIDTH-1:0];
                fix_hi = acc_reg[2*WIDTH-1:WIDTH];
                // A zero divisor never borrows, so the remainder already holds the dividend.
                if (opa_reg == '0) begin
                    fix_lo = '1;
                    fix_dz = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            op_reg    <= '0;
            neg_reg   <= 1'b0;
            opa_reg   <= '0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ResultLo  <= '0;
            ResultHi  <= '0;
            DivZero   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (accept) begin
                        op_reg    <= ALUControl[1:0];
                        neg_reg   <= cap_neg;
                        opa_reg   <= cap_opa;
                        acc_reg   <= {{WIDTH{1'b0}}, cap_low};
                        cnt_reg   <= '0;
                        busy      <= 1'b1;
                        state_reg <= RUN;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    acc_reg <= (op_reg == OP_DIV) ? div_next : mul_next;
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == LAST_ITER) begin
                        state_reg <= FIX;
                    end
                end
                FIX: begin
                    ResultLo  <= fix_lo;
                    ResultHi  <= fix_hi;
                    DivZero   <= fix_dz;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state_reg <= DONE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: fixed vectors, handshake/reset corner cases,
// and random operations against a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_muldiv_seq;

    localparam int W   = 32;
    localparam int LAT = W + 1;   // edges from the sampling edge to the one raising done

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   ALUControl = 3'b000;
    logic [W-1:0] SrcA = '0;
    logic [W-1:0] SrcB = '0;
    logic         busy, done, DivZero;
    logic [W-1:0] ResultLo, ResultHi;

    int total = 0;
    int bad   = 0;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .ALUControl(ALUControl),
        .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done),
        .ResultLo(ResultLo), .ResultHi(ResultHi), .DivZero(DivZero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a, b, lo, hi;
        logic         dz;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] lo, output logic [W-1:0] hi, output logic dz);
        logic [2*W-1:0] p;
        longint         sp;
        dz = 1'b0;
        p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (op)
            3'b100: begin lo = p[W-1:0]; hi = '0; end
            3'b101: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                lo = sp[31:0];
                hi = sp[63:32];
            end
            3'b110: begin lo = p[W-1:0]; hi = p[2*W-1:W]; end
            default: begin
                if (b == '0) begin lo = '1; hi = a; dz = 1'b1; end
                else begin lo = a / b; hi = a % b; end
            end
        endcase
    endfunction

    // Present a request for one edge, then scramble the inputs to prove they are not reused.
    task automatic launch(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        ALUControl = op; SrcA = a; SrcB = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        SrcA = $urandom;
        SrcB = $urandom;
        ALUControl = 3'($urandom_range(0, 7));
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < LAT + 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_and_check(input string name, input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [W-1:0] lo, input logic [W-1:0] hi,
                                 input logic dz);
        int lat;
        @(negedge clk);
        launch(op, a, b);
        check({name, " busy"}, W'(busy), W'(1));
        wait_done(lat);
        check({name, " latency"}, W'(lat), W'(LAT));
        check({name, " lo"}, ResultLo, lo);
        check({name, " hi"}, ResultHi, hi);
        check({name, " divzero"}, W'(DivZero), W'(dz));
        $display("op=%b a=%h b=%h -> lo=%h hi=%h dz=%0d lat=%0d", op, a, b, ResultLo, ResultHi, DivZero, lat);
        @(posedge clk); #1;
        check({name, " done drop"}, W'(done), W'(0));
        check({name, " lo held"}, ResultLo, lo);
        check({name, " dz held"}, W'(DivZero), W'(dz));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] elo, ehi;
        logic         edz;
        int           lat, seen;
        logic [2:0]   rop;
        logic [W-1:0] ra, rb;

        vecs[0] = '{3'b110, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0};
        vecs[1] = '{3'b101, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0};
        vecs[2] = '{3'b101, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 1'b0};
        vecs[3] = '{3'b100, 32'h00010000, 32'h00010001, 32'h00010000, 32'h00000000, 1'b0};
        vecs[4] = '{3'b111, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0};
        vecs[5] = '{3'b111, 32'd100,      32'd0,        32'hFFFFFFFF, 32'd100,      1'b1};
        vecs[6] = '{3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
        vecs[7] = '{3'b111, 32'hFFFFFFFF, 32'h80000001, 32'h00000001, 32'h7FFFFFFE, 1'b0};
        vecs[8] = '{3'b111, 32'd7,        32'd100,      32'd0,        32'd7,        1'b0};

        repeat (2) @(posedge clk);
        #1;
        check("reset busy", W'(busy), W'(0));
        check("reset done", W'(done), W'(0));
        check("reset lo", ResultLo, '0);
        check("reset hi", ResultHi, '0);
        check("reset dz", W'(DivZero), W'(0));
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                          vecs[i].lo, vecs[i].hi, vecs[i].dz);
        end

        // start pulsed at cycle 5 of a DIV must not disturb it
        @(negedge clk);
        launch(3'b111, 32'd1000, 32'd33);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; ALUControl = 3'b110; SrcA = 32'd5; SrcB = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat);
        check("midstart latency", W'(lat), W'(LAT - 5));
        check("midstart lo", ResultLo, 32'd30);
        check("midstart hi", ResultHi, 32'd10);
        $display("midstart: lo=%h hi=%h lat=%0d", ResultLo, ResultHi, lat);

        // back-to-back: new start issued inside the DONE cycle
        @(negedge clk);
        launch(3'b110, 32'h12345678, 32'h9ABCDEF0);
        wait_done(lat);
        model(3'b110, 32'h12345678, 32'h9ABCDEF0, elo, ehi, edz);
        check("b2b first lo", ResultLo, elo);
        check("b2b first hi", ResultHi, ehi);
        launch(3'b111, 32'd100, 32'd7);
        check("b2b done drop", W'(done), W'(0));
        check("b2b busy", W'(busy), W'(1));
        wait_done(lat);
        check("b2b latency", W'(lat), W'(LAT));
        check("b2b lo", ResultLo, 32'd14);
        check("b2b hi", ResultHi, 32'd2);
        $display("b2b: lo=%h hi=%h lat=%0d", ResultLo, ResultHi, lat);

        // non-extended opcode is ignored
        @(negedge clk);
        launch(3'b010, 32'd5, 32'd6);
        seen = 0;
        repeat (40) begin
            if (busy || done) seen++;
            @(posedge clk); #1;
        end
        check("badop activity", W'(seen), W'(0));
        check("badop lo held", ResultLo, 32'd14);
        $display("badop: activity=%0d lo=%h", seen, ResultLo);

        // reset in the middle of a DIV clears everything at once
        @(negedge clk);
        launch(3'b111, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midreset busy", W'(busy), W'(0));
        check("midreset done", W'(done), W'(0));
        check("midreset lo", ResultLo, '0);
        check("midreset hi", ResultHi, '0);
        check("midreset dz", W'(DivZero), W'(0));
        $display("midreset: busy=%0d done=%0d lo=%h hi=%h", busy, done, ResultLo, ResultHi);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        run_and_check("post reset", 3'b111, 32'd100, 32'd0, 32'hFFFFFFFF, 32'd100, 1'b1);

        for (int i = 0; i < 40; i++) begin
            rop = 3'(4 + $urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0: ra = '0;
                1: ra = '1;
                2: ra = 32'h80000000;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = '1;
                2: rb = 32'h80000000;
                3: rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            model(rop, ra, rb, elo, ehi, edz);
            run_and_check($sformatf("rnd%0d", i), rop, ra, rb, elo, ehi, edz);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
